// File: rtl/fetch_stage_if.sv
// fetch_stage_if: stall/redirect control, instruction memory port and decode-facing outputs of the fetch stage
interface fetch_stage_if;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_en_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        valid_o;
   logic        misalign_o;
   logic [31:0] fetch_count_o;
   modport master (
      input  stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
      output imem_en_o, imem_addr_o, inst_o, pc_o, valid_o, misalign_o, fetch_count_o
   );
   modport slave (
      output stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
      input  imem_en_o, imem_addr_o, inst_o, pc_o, valid_o, misalign_o, fetch_count_o
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch; owns the PC and drives a one-cycle synchronous instruction memory
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h4000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input logic          clk,
   input logic          rst,
   fetch_stage_if.master bus
);
   logic [31:0] next_pc_q, pc_d_q, cnt_q, req_addr;
   logic        vld_q, misalign_q, valid;
   // redirect beats stall; a stall only replays when there is a real instruction to hold
   always_comb begin
      req_addr = bus.redirect_i ? {bus.redirect_pc_i[31:2], 2'b00} :
                 (bus.stall_i && vld_q) ? pc_d_q : next_pc_q;
      valid             = vld_q && !bus.redirect_i;
      bus.imem_en_o     = rst;
      bus.imem_addr_o   = req_addr;
      bus.valid_o       = valid;
      bus.pc_o          = pc_d_q;
      bus.inst_o        = valid ? bus.imem_rdata_i : NOP_INST;
      bus.misalign_o    = misalign_q;
      bus.fetch_count_o = cnt_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         next_pc_q  <= RESET_PC;
         pc_d_q     <= RESET_PC;
         vld_q      <= 1'b0;
         misalign_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         pc_d_q     <= req_addr;
         next_pc_q  <= req_addr + 32'd4;
         vld_q      <= 1'b1;
         misalign_q <= bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);
         if (valid && !bus.stall_i) cnt_q <= cnt_q + 32'd1;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven directed vectors plus reset/stall corner sequences for fetch_stage
module tb_fetch_stage;
   localparam logic [31:0] KEY = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;
   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] addr;
      logic        mis;
      logic [31:0] cnt;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   vec_t vecs[$];
   fetch_stage_if bus();
   fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // memory returns address ^ KEY one cycle after the request
   always @(posedge clk) bus.imem_rdata_i <= bus.imem_addr_o ^ KEY;
   function automatic vec_t mk(input logic stall, input logic redir, input logic [31:0] rpc,
                               input logic valid, input logic [31:0] pc, input logic [31:0] addr,
                               input logic mis, input logic [31:0] cnt);
      vec_t v;
      v.stall = stall; v.redir = redir; v.rpc = rpc; v.valid = valid;
      v.pc = pc; v.addr = addr; v.mis = mis; v.cnt = cnt;
      return v;
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic apply(input string tag, input vec_t v);
      bus.stall_i       = v.stall;
      bus.redirect_i    = v.redir;
      bus.redirect_pc_i = v.rpc;
      #1;
      check({tag, " en"},    {31'd0, bus.imem_en_o}, 32'd1);
      check({tag, " valid"}, {31'd0, bus.valid_o}, {31'd0, v.valid});
      check({tag, " pc"},    bus.pc_o, v.pc);
      check({tag, " addr"},  bus.imem_addr_o, v.addr);
      check({tag, " inst"},  bus.inst_o, v.valid ? (v.pc ^ KEY) : NOP);
      check({tag, " mis"},   {31'd0, bus.misalign_o}, {31'd0, v.mis});
      check({tag, " cnt"},   bus.fetch_count_o, v.cnt);
   endtask
   task automatic check_reset(input string tag);
      check({tag, " en"},    {31'd0, bus.imem_en_o}, 32'd0);
      check({tag, " valid"}, {31'd0, bus.valid_o}, 32'd0);
      check({tag, " pc"},    bus.pc_o, 32'h4000_0000);
      check({tag, " inst"},  bus.inst_o, NOP);
      check({tag, " mis"},   {31'd0, bus.misalign_o}, 32'd0);
      check({tag, " cnt"},   bus.fetch_count_o, 32'd0);
   endtask
   initial begin
      bus.stall_i = 1'b0;
      bus.redirect_i = 1'b0;
      bus.redirect_pc_i = '0;
      //              stall redir rpc            valid pc             addr           mis cnt
      vecs.push_back(mk(0, 0, 32'h0,          0, 32'h4000_0000, 32'h4000_0000, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,          1, 32'h4000_0000, 32'h4000_0004, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,          1, 32'h4000_0004, 32'h4000_0008, 0, 1));
      vecs.push_back(mk(1, 0, 32'h0,          1, 32'h4000_0008, 32'h4000_0008, 0, 2));
      vecs.push_back(mk(1, 0, 32'h0,          1, 32'h4000_0008, 32'h4000_0008, 0, 2));
      vecs.push_back(mk(1, 0, 32'h0,          1, 32'h4000_0008, 32'h4000_0008, 0, 2));
      vecs.push_back(mk(0, 0, 32'h0,          1, 32'h4000_0008, 32'h4000_000C, 0, 2));
      vecs.push_back(mk(0, 0, 32'h0,          1, 32'h4000_000C, 32'h4000_0010, 0, 3));
      vecs.push_back(mk(0, 1, 32'h4000_0100,  0, 32'h4000_0010, 32'h4000_0100, 0, 4));
      vecs.push_back(mk(0, 0, 32'h0,          1, 32'h4000_0100, 32'h4000_0104, 0, 4));
      vecs.push_back(mk(1, 1, 32'h4000_0200,  0, 32'h4000_0104, 32'h4000_0200, 0, 5));
      vecs.push_back(mk(1, 0, 32'h0,          1, 32'h4000_0200, 32'h4000_0200, 0, 5));
      vecs.push_back(mk(1, 0, 32'h0,          1, 32'h4000_0200, 32'h4000_0200, 0, 5));
      vecs.push_back(mk(0, 0, 32'h0,          1, 32'h4000_0200, 32'h4000_0204, 0, 5));
      vecs.push_back(mk(0, 1, 32'h4000_0302,  0, 32'h4000_0204, 32'h4000_0300, 0, 6));
      vecs.push_back(mk(0, 0, 32'h0,          1, 32'h4000_0300, 32'h4000_0304, 1, 6));
      vecs.push_back(mk(0, 1, 32'h4000_0500,  0, 32'h4000_0304, 32'h4000_0500, 0, 7));
      vecs.push_back(mk(0, 1, 32'h4000_0600,  0, 32'h4000_0500, 32'h4000_0600, 0, 7));
      vecs.push_back(mk(1, 0, 32'h0,          1, 32'h4000_0600, 32'h4000_0600, 0, 7));
      vecs.push_back(mk(0, 1, 32'hFFFF_FFFC,  0, 32'h4000_0600, 32'hFFFF_FFFC, 0, 7));
      vecs.push_back(mk(0, 0, 32'h0,          1, 32'hFFFF_FFFC, 32'h0000_0000, 0, 7));
      vecs.push_back(mk(0, 0, 32'h0,          1, 32'h0000_0000, 32'h0000_0004, 0, 8));
      repeat (2) @(negedge clk);
      check_reset("reset");
      rst = 1'b1;
      foreach (vecs[i]) begin
         apply($sformatf("v%0d", i), vecs[i]);
         @(negedge clk);
      end
      // asynchronous reset between edges must clear outputs immediately
      #2 rst = 1'b0;
      #1 check_reset("async_rst");
      @(negedge clk);
      rst = 1'b1;
      apply("rst_stall0", mk(1, 0, 32'h0, 0, 32'h4000_0000, 32'h4000_0000, 0, 0));
      @(negedge clk);
      apply("rst_first", mk(0, 0, 32'h0, 1, 32'h4000_0000, 32'h4000_0004, 0, 0));
      @(negedge clk);
      apply("rst_second", mk(0, 0, 32'h0, 1, 32'h4000_0004, 32'h4000_0008, 0, 1));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
